// File: rtl/datapath_io_pkg.sv
// Shared encodings for the accumulator datapath: bus sources and ALU functions.
package datapath_io_pkg;
  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_PASS_DR = 3'd2;
  localparam logic [2:0] OP_CMA     = 3'd3;
  localparam logic [2:0] OP_CIR     = 3'd4;
  localparam logic [2:0] OP_CIL     = 3'd5;
  localparam logic [2:0] OP_INP     = 3'd6;
  localparam logic [2:0] OP_PASS_AC = 3'd7;
endpackage

// File: rtl/datapath_io_io_port.sv
// INPR/OUTR with FGI/FGO flags and device handshakes; one-edge latency, flags are the backpressure.
module io_port #(
  parameter int IO_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IO_W-1:0] in_data,
  output logic            in_ready,
  input  logic            inp_take,
  input  logic            outr_ld,
  input  logic [IO_W-1:0] outr_d,
  output logic            out_valid,
  output logic [IO_W-1:0] out_data,
  input  logic            out_ready,
  output logic [IO_W-1:0] inpr,
  output logic            fgi,
  output logic            fgo
);
  assign in_ready  = ~fgi;
  assign out_valid = ~fgo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inpr     <= '0;
      out_data <= '0;
      fgi      <= 1'b0;
      fgo      <= 1'b1;
    end else begin
      if (in_valid && in_ready) begin
        inpr <= in_data;
        fgi  <= 1'b1;
      end else if (inp_take) begin
        fgi <= 1'b0;
      end
      // A new OUTR load overrides a completing handshake in the same cycle.
      if (outr_ld) begin
        out_data <= outr_d;
        fgo      <= 1'b0;
      end else if (out_valid && out_ready) begin
        fgo <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/gen_reg.sv
// Generic register with clear > load > increment priority; updates one edge after the strobe.
module gen_reg #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic         incr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    q <= '0;
    else if (clr)  q <= '0;
    else if (ld)   q <= d;
    else if (incr) q <= q + 1'b1;
  end
endmodule

// File: rtl/datapath_io.sv
// Accumulator datapath: registers, bus mux, ALU, sequence counter, flags and I/O port.
// Every register updates one edge after its strobe; memory read data is used combinationally.
module datapath_io
  import datapath_io_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int IO_W   = 8,
  parameter int SC_W   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 AR_ld, PC_ld, DR_ld, AC_ld, IR_ld, TR_ld,
  input  logic                 AR_incr, PC_incr, DR_incr, AC_incr, TR_incr,
  input  logic                 AR_clr, PC_clr, DR_clr, AC_clr, TR_clr,
  input  logic                 E_ld, E_clr, E_cmp,
  input  logic                 IEN_set, IEN_clr,
  input  logic                 R_chk, R_clr,
  input  logic                 sc_incr, sc_clr,
  input  logic                 inp_take,
  input  logic                 outr_ld,
  input  logic [2:0]           bus_select,
  input  logic [2:0]           alu_op_select,
  input  logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_we_o,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 in_valid,
  input  logic [IO_W-1:0]      in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [IO_W-1:0]      out_data,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    AR_out, PC_out,
  output logic [DATA_W-1:0]    DR_out, AC_out, IR_out, TR_out,
  output logic                 E_out, IEN_out, R_out, FGI_out, FGO_out,
  output logic [SC_W-1:0]      SC_out,
  output logic [2**SC_W-1:0]   T,
  output logic                 CO, OVF, N, Z
);
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   sum;
  logic              e_next;
  logic [IO_W-1:0]   inpr;

  always_comb begin
    bus = '0;
    case (bus_select)
      SEL_AR:  bus[ADDR_W-1:0] = AR_out;
      SEL_PC:  bus[ADDR_W-1:0] = PC_out;
      SEL_DR:  bus = DR_out;
      SEL_AC:  bus = AC_out;
      SEL_IR:  bus = IR_out;
      SEL_TR:  bus = TR_out;
      SEL_MEM: bus = mem_rdata;
      default: bus = '0;
    endcase
  end

  assign sum = {1'b0, AC_out} + {1'b0, DR_out};

  // CO reports the bit leaving the word: ADD carry or the rotated-out bit.
  always_comb begin
    alu_res = AC_out;
    e_next  = E_out;
    CO      = 1'b0;
    OVF     = 1'b0;
    case (alu_op_select)
      OP_AND:     alu_res = AC_out & DR_out;
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        e_next  = sum[DATA_W];
        CO      = sum[DATA_W];
        OVF     = (AC_out[DATA_W-1] == DR_out[DATA_W-1]) &&
                  (sum[DATA_W-1] != AC_out[DATA_W-1]);
      end
      OP_PASS_DR: alu_res = DR_out;
      OP_CMA:     alu_res = ~AC_out;
      OP_CIR: begin
        alu_res = {E_out, AC_out[DATA_W-1:1]};
        e_next  = AC_out[0];
        CO      = AC_out[0];
      end
      OP_CIL: begin
        alu_res = {AC_out[DATA_W-2:0], E_out};
        e_next  = AC_out[DATA_W-1];
        CO      = AC_out[DATA_W-1];
      end
      OP_INP:     alu_res[IO_W-1:0] = inpr;
      default:    alu_res = AC_out;
    endcase
  end

  assign N = alu_res[DATA_W-1];
  assign Z = (alu_res == '0);

  gen_reg #(.W(ADDR_W)) u_ar (.clock, .reset, .clr(AR_clr), .ld(AR_ld), .incr(AR_incr),
                              .d(bus[ADDR_W-1:0]), .q(AR_out));
  gen_reg #(.W(ADDR_W)) u_pc (.clock, .reset, .clr(PC_clr), .ld(PC_ld), .incr(PC_incr),
                              .d(bus[ADDR_W-1:0]), .q(PC_out));
  gen_reg #(.W(DATA_W)) u_dr (.clock, .reset, .clr(DR_clr), .ld(DR_ld), .incr(DR_incr),
                              .d(bus), .q(DR_out));
  gen_reg #(.W(DATA_W)) u_ac (.clock, .reset, .clr(AC_clr), .ld(AC_ld), .incr(AC_incr),
                              .d(alu_res), .q(AC_out));
  gen_reg #(.W(DATA_W)) u_ir (.clock, .reset, .clr(1'b0), .ld(IR_ld), .incr(1'b0),
                              .d(bus), .q(IR_out));
  gen_reg #(.W(DATA_W)) u_tr (.clock, .reset, .clr(TR_clr), .ld(TR_ld), .incr(TR_incr),
                              .d(bus), .q(TR_out));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      E_out   <= 1'b0;
      IEN_out <= 1'b0;
      R_out   <= 1'b0;
      SC_out  <= '0;
    end else begin
      if (E_clr)      E_out <= 1'b0;
      else if (E_ld)  E_out <= e_next;
      else if (E_cmp) E_out <= ~E_out;

      if (IEN_clr)      IEN_out <= 1'b0;
      else if (IEN_set) IEN_out <= 1'b1;

      if (R_clr)      R_out <= 1'b0;
      else if (R_chk) R_out <= IEN_out & (FGI_out | FGO_out);

      if (sc_clr)       SC_out <= '0;
      else if (sc_incr) SC_out <= SC_out + 1'b1;
    end
  end

  always_comb begin
    T = '0;
    T[SC_out] = 1'b1;
  end

  io_port #(.IO_W(IO_W)) u_io (
    .clock, .reset, .in_valid, .in_data, .in_ready, .inp_take, .outr_ld,
    .outr_d(AC_out[IO_W-1:0]), .out_valid, .out_data, .out_ready,
    .inpr, .fgi(FGI_out), .fgo(FGO_out)
  );

  assign mem_addr  = AR_out;
  assign mem_wdata = bus;
  assign mem_we_o  = mem_we;
endmodule

// File: tb/tb_datapath_io.sv
// Scoreboard bench for datapath_io: expectations queued with stimulus, popped after the DUT responds.
module tb_datapath_io;
  logic clock = 1'b0;
  logic reset;
  logic AR_ld, PC_ld, DR_ld, AC_ld, IR_ld, TR_ld;
  logic AR_incr, PC_incr, DR_incr, AC_incr, TR_incr;
  logic AR_clr, PC_clr, DR_clr, AC_clr, TR_clr;
  logic E_ld, E_clr, E_cmp, IEN_set, IEN_clr, R_chk, R_clr, sc_incr, sc_clr;
  logic inp_take, outr_ld, mem_we, mem_we_o, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] bus_select, alu_op_select;
  logic [11:0] mem_addr, AR_out, PC_out;
  logic [15:0] mem_wdata, mem_rdata, DR_out, AC_out, IR_out, TR_out, T;
  logic [7:0] in_data, out_data;
  logic E_out, IEN_out, R_out, FGI_out, FGO_out, CO, OVF, N, Z;
  logic [3:0] SC_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clock = ~clock;

  datapath_io dut (
    .clock(clock), .reset(reset),
    .AR_ld(AR_ld), .PC_ld(PC_ld), .DR_ld(DR_ld), .AC_ld(AC_ld), .IR_ld(IR_ld), .TR_ld(TR_ld),
    .AR_incr(AR_incr), .PC_incr(PC_incr), .DR_incr(DR_incr), .AC_incr(AC_incr), .TR_incr(TR_incr),
    .AR_clr(AR_clr), .PC_clr(PC_clr), .DR_clr(DR_clr), .AC_clr(AC_clr), .TR_clr(TR_clr),
    .E_ld(E_ld), .E_clr(E_clr), .E_cmp(E_cmp), .IEN_set(IEN_set), .IEN_clr(IEN_clr),
    .R_chk(R_chk), .R_clr(R_clr), .sc_incr(sc_incr), .sc_clr(sc_clr),
    .inp_take(inp_take), .outr_ld(outr_ld), .bus_select(bus_select),
    .alu_op_select(alu_op_select), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we_o(mem_we_o), .mem_rdata(mem_rdata),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .AR_out(AR_out), .PC_out(PC_out), .DR_out(DR_out), .AC_out(AC_out),
    .IR_out(IR_out), .TR_out(TR_out), .E_out(E_out), .IEN_out(IEN_out),
    .R_out(R_out), .FGI_out(FGI_out), .FGO_out(FGO_out), .SC_out(SC_out),
    .T(T), .CO(CO), .OVF(OVF), .N(N), .Z(Z)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    {AR_ld, PC_ld, DR_ld, AC_ld, IR_ld, TR_ld} = '0;
    {AR_incr, PC_incr, DR_incr, AC_incr, TR_incr} = '0;
    {AR_clr, PC_clr, DR_clr, AC_clr, TR_clr} = '0;
    {E_ld, E_clr, E_cmp, IEN_set, IEN_clr, R_chk, R_clr, sc_incr, sc_clr} = '0;
    {inp_take, outr_ld, mem_we, in_valid, out_ready} = '0;
    bus_select = 3'd0; alu_op_select = 3'd7; in_data = 8'h00;
  endtask

  task automatic put_dr(input logic [15:0] v);
    bus_select = 3'd7; mem_rdata = v; DR_ld = 1'b1;
    tick;
    DR_ld = 1'b0;
  endtask

  task automatic load_ac(input logic [15:0] v);
    put_dr(v);
    alu_op_select = 3'd2; AC_ld = 1'b1;
    tick;
    AC_ld = 1'b0; alu_op_select = 3'd7;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    load_ac(16'h1234);
    sc_incr = 1'b1; tick; tick; sc_incr = 1'b0;
    outr_ld = 1'b1; tick; outr_ld = 1'b0;
    @(posedge clock); #3;
    reset = 1'b0;
    exp_q.push_back({16'h0000, 16'h0001});
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({AC_out, T} !== e) begin
      errors++; $display("FAIL reset_ac_t got %h/%h want %h/%h", AC_out, T, e[31:16], e[15:0]);
    end
    exp_q.push_back({16'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    e = exp_q.pop_front();
    checks++;
    if ({DR_out, SC_out, FGO_out, in_ready, out_valid, FGI_out, out_data} !== e) begin
      errors++; $display("FAIL reset_flags got %h want %h",
                         {DR_out, SC_out, FGO_out, in_ready, out_valid, FGI_out, out_data}, e);
    end
    #4 reset = 1'b1;
    tick;
  endtask

  task automatic test_add_alu;
    load_ac(16'h0001);
    put_dr(16'h7FFF);
    alu_op_select = 3'd1;
    exp_q.push_back({28'h0, 4'b1100});
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({OVF, N, CO, Z} !== e[3:0]) begin
      errors++; $display("FAIL add_flags got %b want %b", {OVF, N, CO, Z}, e[3:0]);
    end
    AC_ld = 1'b1; E_ld = 1'b1;
    exp_q.push_back({15'h0, 1'b0, 16'h8000});
    tick;
    AC_ld = 1'b0; E_ld = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({E_out, AC_out} !== e[16:0]) begin
      errors++; $display("FAIL add_result got %b/%h want %b/%h", E_out, AC_out, e[16], e[15:0]);
    end
    // CIL of 8000 with E=0 -> 0000, E=1, Z=1; then CIR -> 8000, E=0
    alu_op_select = 3'd5; #1;
    exp_q.push_back({31'h0, 1'b1});
    e = exp_q.pop_front();
    checks++;
    if (Z !== e[0]) begin
      errors++; $display("FAIL cil_zero got %b want %b", Z, e[0]);
    end
    AC_ld = 1'b1; E_ld = 1'b1;
    exp_q.push_back({15'h0, 1'b1, 16'h0000});
    tick;
    e = exp_q.pop_front();
    checks++;
    if ({E_out, AC_out} !== e[16:0]) begin
      errors++; $display("FAIL cil got %b/%h want %b/%h", E_out, AC_out, e[16], e[15:0]);
    end
    alu_op_select = 3'd4;
    exp_q.push_back({15'h0, 1'b0, 16'h8000});
    tick;
    AC_ld = 1'b0; E_ld = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({E_out, AC_out} !== e[16:0]) begin
      errors++; $display("FAIL cir got %b/%h want %b/%h", E_out, AC_out, e[16], e[15:0]);
    end
    E_cmp = 1'b1; tick; E_cmp = 1'b0;
    alu_op_select = 3'd5; E_clr = 1'b1; E_ld = 1'b1;
    exp_q.push_back(32'h0);
    tick;
    E_clr = 1'b0; E_ld = 1'b0; alu_op_select = 3'd7;
    e = exp_q.pop_front();
    checks++;
    if (E_out !== e[0]) begin
      errors++; $display("FAIL e_clr_prio got %b want %b", E_out, e[0]);
    end
  endtask

  task automatic test_regs;
    bus_select = 3'd7; mem_rdata = 16'hFFFF; AR_ld = 1'b1;
    exp_q.push_back({20'h0, 12'hFFF});
    tick;
    AR_ld = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (AR_out !== e[11:0]) begin
      errors++; $display("FAIL ar_load got %h want %h", AR_out, e[11:0]);
    end
    AR_incr = 1'b1;
    exp_q.push_back(32'h0);
    tick;
    AR_incr = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({AR_out, mem_addr} !== e[23:0]) begin
      errors++; $display("FAIL ar_wrap got %h/%h want 0", AR_out, mem_addr);
    end
    mem_rdata = 16'h0456; AR_ld = 1'b1; AR_clr = 1'b1;
    exp_q.push_back(32'h0);
    tick;
    AR_ld = 1'b0; AR_clr = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (AR_out !== e[11:0]) begin
      errors++; $display("FAIL ar_clr_prio got %h want %h", AR_out, e[11:0]);
    end
    mem_rdata = 16'hFABC; PC_ld = 1'b1; tick; PC_ld = 1'b0;
    bus_select = 3'd2; DR_ld = 1'b1;
    exp_q.push_back({16'h0, 16'h0ABC});
    #1;
    e = exp_q.pop_front();
    checks++;
    if (mem_wdata !== e[15:0]) begin
      errors++; $display("FAIL bus_pc got %h want %h", mem_wdata, e[15:0]);
    end
    exp_q.push_back({16'h0, 16'h0ABC});
    tick;
    DR_ld = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (DR_out !== e[15:0]) begin
      errors++; $display("FAIL dr_from_pc got %h want %h", DR_out, e[15:0]);
    end
  endtask

  task automatic test_input;
    in_valid = 1'b1; in_data = 8'hA5;
    exp_q.push_back({30'h0, 1'b1, 1'b0});
    tick;
    e = exp_q.pop_front();
    checks++;
    if ({FGI_out, in_ready} !== e[1:0]) begin
      errors++; $display("FAIL in_push got %b%b want %b", FGI_out, in_ready, e[1:0]);
    end
    in_data = 8'h3C; tick;
    in_valid = 1'b0;
    load_ac(16'h1200);
    inp_take = 1'b1; alu_op_select = 3'd6; AC_ld = 1'b1;
    exp_q.push_back({15'h0, 1'b0, 16'h12A5});
    tick;
    inp_take = 1'b0; AC_ld = 1'b0; alu_op_select = 3'd7;
    e = exp_q.pop_front();
    checks++;
    if ({FGI_out, AC_out} !== e[16:0]) begin
      errors++; $display("FAIL inp got %b/%h want %b/%h", FGI_out, AC_out, e[16], e[15:0]);
    end
  endtask

  task automatic test_output;
    load_ac(16'h0042);
    outr_ld = 1'b1;
    exp_q.push_back({22'h0, 1'b1, 1'b0, 8'h42});
    tick;
    outr_ld = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, FGO_out, out_data} !== e[9:0]) begin
      errors++; $display("FAIL out_load got %b%b/%h want %h", out_valid, FGO_out, out_data, e[9:0]);
    end
    out_ready = 1'b1;
    exp_q.push_back({30'h0, 1'b0, 1'b1});
    tick;
    out_ready = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, FGO_out} !== e[1:0]) begin
      errors++; $display("FAIL out_hs got %b%b want %b", out_valid, FGO_out, e[1:0]);
    end
    outr_ld = 1'b1; tick; outr_ld = 1'b0;
    load_ac(16'h0099);
    outr_ld = 1'b1; out_ready = 1'b1;
    exp_q.push_back({23'h0, 1'b0, 8'h99});
    tick;
    outr_ld = 1'b0; out_ready = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({FGO_out, out_data} !== e[8:0]) begin
      errors++; $display("FAIL out_ld_prio got %b/%h want %b/%h", FGO_out, out_data, e[8], e[7:0]);
    end
  endtask

  task automatic test_intr_sc;
    IEN_set = 1'b1; tick; IEN_set = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick; in_valid = 1'b0;
    R_chk = 1'b1;
    exp_q.push_back(32'h1);
    tick;
    R_chk = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (R_out !== e[0]) begin
      errors++; $display("FAIL r_set got %b want %b", R_out, e[0]);
    end
    IEN_set = 1'b1; IEN_clr = 1'b1; tick; IEN_set = 1'b0; IEN_clr = 1'b0;
    R_chk = 1'b1;
    exp_q.push_back(32'h0);
    tick;
    R_chk = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({IEN_out, R_out} !== e[1:0]) begin
      errors++; $display("FAIL r_ien_off got %b%b want %b", IEN_out, R_out, e[1:0]);
    end
    IEN_set = 1'b1; tick; IEN_set = 1'b0;
    R_chk = 1'b1; R_clr = 1'b1;
    exp_q.push_back(32'h0);
    tick;
    R_chk = 1'b0; R_clr = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (R_out !== e[0]) begin
      errors++; $display("FAIL r_clr_prio got %b want %b", R_out, e[0]);
    end
    sc_clr = 1'b1; tick; sc_clr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      sc_incr = 1'b1;
      exp_q.push_back({12'h0, 4'(i), 16'(1) << (i % 16)});
      tick;
      e = exp_q.pop_front();
      checks++;
      if ({SC_out, T} !== e[19:0]) begin
        errors++; $display("FAIL sc_step%0d got %h/%h want %h/%h", i, SC_out, T, e[19:16], e[15:0]);
      end
    end
    sc_incr = 1'b1; tick;
    sc_clr = 1'b1;
    exp_q.push_back({12'h0, 4'h0, 16'h0001});
    tick;
    sc_clr = 1'b0; sc_incr = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({SC_out, T} !== e[19:0]) begin
      errors++; $display("FAIL sc_clr_prio got %h/%h want %h/%h", SC_out, T, e[19:16], e[15:0]);
    end
  endtask

  initial begin
    reset = 1'b0;
    mem_rdata = 16'h0;
    idle;
    #12;
    test_reset;
    test_add_alu;
    test_regs;
    test_input;
    test_output;
    test_intr_sc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/datapath_io.md
Name: datapath_io

Overview:
Parametrised second-generation accumulator datapath for the basic computer. Generalised data/address width, external memory port, on-chip sequence counter with one-hot timing outputs, INPR/OUTR I/O registers with FGI/FGO ready/valid handshakes, and interrupt flip-flop R. Sits between the control unit and external memory and I/O devices; the control unit drives all strobes.

Parameters:
DATA_W, 16, width of DR/AC/IR/TR and bus; must be >= ADDR_W and >= IO_W
ADDR_W, 12, width of AR/PC and memory address
IO_W, 8, width of INPR/OUTR and device data
SC_W, 4, sequence-counter width; T output has 2**SC_W bits

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low
AR_ld, PC_ld, DR_ld, AC_ld, IR_ld, TR_ld  input  1 each  load strobes
AR_incr, PC_incr, DR_incr, AC_incr, TR_incr  input  1 each  increment strobes
AR_clr, PC_clr, DR_clr, AC_clr, TR_clr  input  1 each  synchronous clear strobes
E_ld, E_clr, E_cmp  input  1 each  E load from ALU / clear / complement
IEN_set, IEN_clr  input  1 each  interrupt enable control
R_chk, R_clr  input  1 each  sample interrupt request / clear R
sc_incr, sc_clr  input  1 each  sequence counter control
inp_take  input  1  INP instruction: clears FGI
outr_ld  input  1  OUT instruction: OUTR <= AC[IO_W-1:0], clears FGO
bus_select  input  3  bus source
alu_op_select  input  3  ALU function
mem_we  input  1  memory write strobe, passed to mem_we_o
mem_addr  output  ADDR_W  equals AR
mem_wdata  output  DATA_W  equals bus
mem_we_o  output  1  equals mem_we
mem_rdata  input  DATA_W  combinational read data for address mem_addr
in_valid  input  1  device has input byte
in_data  input  IO_W  device input byte
in_ready  output  1  ~FGI
out_valid  output  1  ~FGO
out_data  output  IO_W  OUTR
out_ready  input  1  device accepts OUTR
AR_out, PC_out  output  ADDR_W  register values
DR_out, AC_out, IR_out, TR_out  output  DATA_W  register values
E_out, IEN_out, R_out, FGI_out, FGO_out  output  1 each  flag values
SC_out  output  SC_W  sequence count
T  output  2**SC_W  one-hot decode of SC_out
CO, OVF, N, Z  output  1 each  combinational ALU flags

Behaviour:
- Reset (reset=0, async): all registers, SC, E, IEN, R, FGI and OUTR are 0; FGO=1. Outputs therefore: T=1, in_ready=1, out_valid=0.
- Register priority per clock: clr > ld > incr. Increment wraps modulo 2**width. E priority: E_clr > E_ld > E_cmp.
- Bus select values: 0 zero, 1 AR (zero-extended), 2 PC (zero-extended), 3 DR, 4 AC, 5 IR, 6 TR, 7 mem_rdata. AR/PC/IR/TR/DR load from bus; AR/PC take bus[ADDR_W-1:0].
- AC loads ALU output. ALU op values: 0 AND(AC,DR), 1 ADD(AC,DR) with E_next=carry, 2 pass DR, 3 ~AC, 4 CIR {E,AC} with E_next=AC[0], 5 CIL with E_next=AC[DATA_W-1], 6 INP: AC[IO_W-1:0]=INPR with upper bits kept, 7 pass AC.
- ALU flags: CO=carry, OVF=signed overflow (ADD only, else 0), N=result MSB, Z=(result==0). All are combinational.
- SC: sc_clr beats sc_incr; wraps from all-ones to 0; T is always exactly one-hot.
- Input port: when in_valid & in_ready, INPR<=in_data and FGI<=1 on the same edge. inp_take clears FGI. Push and take cannot coincide because in_ready=0 while FGI=1.
- Output port: outr_ld loads OUTR and clears FGO, which raises out_valid the next cycle. When out_valid & out_ready, FGO<=1. If outr_ld and an out handshake occur in the same cycle, outr_ld wins: FGO=0 and OUTR takes the new value.
- IEN: IEN_clr beats IEN_set.
- R: R_clr beats R_chk. On R_chk, R<=IEN & (FGI|FGO), sampled pre-edge. R holds otherwise.
- Latency: every register updates one edge after its strobe. The memory path has no internal wait states.
- Reset mid-handshake returns FGO to 1 and drops any pending input.

Decomposition:
- Shared package holds the bus-select constants (SEL_ZERO..SEL_MEM) and ALU-op constants (OP_AND..OP_PASS_AC).
- Reuse the existing generic register for AR/PC/DR/AC/IR/TR, with a new async active-low reset.
- One natural sub-module, io_port: INPR, OUTR, FGI, FGO and both handshakes, parametrised by IO_W.

Test Plan:
- Reset with reset=0 mid-cycle -> all registers 0, FGO=1, T=16'h0001, in_ready=1, out_valid=0, asynchronously.
- bus_select=7, mem_rdata=16'h7FFF, DR_ld; then alu_op=1 with AC=16'h0001, AC_ld, E_ld -> AC=16'h8000, OVF=1, N=1, E=0.
- AR=12'hFFF, AR_incr -> AR=0; AR_clr and AR_ld in the same cycle -> AR=0.
- in_valid=1, in_data=8'hA5 -> FGI=1, in_ready=0; inp_take with alu_op=6, AC=16'h1200, AC_ld -> AC=16'h12A5, FGI=0.
- AC=16'h0042, outr_ld -> out_data=8'h42, out_valid=1; out_ready=1 one cycle -> FGO=1; outr_ld in the same cycle as out_ready -> FGO stays 0.
- IEN_set, FGI=1, R_chk -> R=1; IEN=0, R_chk -> R=0; R_clr with R_chk -> R=0; sc_incr 16 times -> SC wraps to 0, T=1.
